// File: rtl/jtvigil_obj_linebuf_pkg.sv
// jtvigil_pkg: shared constants and state type for the object line buffer
package jtvigil_pkg;
   localparam int         OBJ_AW    = 9;
   localparam int         OBJ_DW    = 8;
   localparam logic [3:0] OBJ_ALPHA = 4'hF;
   localparam logic [7:0] OBJ_BLANK = 8'hFF;
   typedef enum logic {ST_INIT, ST_RUN} obj_st_e;
endpackage

// File: rtl/jtvigil_obj_linebuf_if.sv
// jtvigil_obj_linebuf_if: drawer/video-side bus of the object line buffer
interface jtvigil_obj_linebuf_if #(
   parameter int AW = jtvigil_pkg::OBJ_AW,
   parameter int DW = jtvigil_pkg::OBJ_DW
);
   logic          LHBL, flip, we, rd, init_done;
   logic [DW-1:0] wr_data, rd_data;
   logic [AW-1:0] wr_addr, rd_addr;
   modport master(output LHBL, flip, wr_data, wr_addr, we, rd_addr, rd, input rd_data, init_done);
   modport slave(input LHBL, flip, wr_data, wr_addr, we, rd_addr, rd, output rd_data, init_done);
endinterface

// File: rtl/jtframe_dual_ram.sv
// jtframe_dual_ram: one bank; port 0 write-only, port 1 read/write with read enable
module jtframe_dual_ram #(
   parameter int AW = 9,
   parameter int DW = 8
)(
   input  logic          clk,
   input  logic [AW-1:0] i_addr0,
   input  logic [DW-1:0] i_data0,
   input  logic          i_we0,
   input  logic [AW-1:0] i_addr1,
   input  logic [DW-1:0] i_data1,
   input  logic          i_we1,
   input  logic          i_re1,
   output logic [DW-1:0] o_q1
);
   logic [DW-1:0] r_mem [2**AW];
   // q only moves on a read so it holds the last pixel across the erase
   always_ff @(posedge clk) begin
      if (i_we0) r_mem[i_addr0] <= i_data0;
      if (i_we1) r_mem[i_addr1] <= i_data1;
      if (i_re1) o_q1 <= r_mem[i_addr1];
   end
endmodule

// File: rtl/jtvigil_obj_linebuf.sv
// jtvigil_obj_linebuf: double-buffered object line buffer with read-and-erase
// and a post-reset clear of both banks.
module jtvigil_obj_linebuf
   import jtvigil_pkg::*;
#(
   parameter int            AW    = OBJ_AW,
   parameter int            DW    = OBJ_DW,
   parameter logic [3:0]    ALPHA = OBJ_ALPHA,
   parameter logic [DW-1:0] BLANK = OBJ_BLANK
)(
   input  logic                  clk,
   input  logic                  rst_n,
   jtvigil_obj_linebuf_if.slave  bus
);
   obj_st_e       r_st, w_st_nx;
   logic [AW-1:0] r_cnt, r_er_addr, w_raddr;
   logic          r_bank, r_lhbl_l, r_er_pend, r_rbank, r_valid, r_init_done;
   logic          w_run, w_opaque;
   logic [DW-1:0] w_q [2];

   assign w_run    = r_st == ST_RUN;
   assign w_opaque = bus.wr_data[3:0] != ALPHA;
   assign w_raddr  = bus.flip ? ~bus.rd_addr : bus.rd_addr;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_st <= ST_INIT;
      else        r_st <= w_st_nx;

   always_comb begin
      w_st_nx = r_st;
      if (r_st == ST_INIT && &r_cnt) w_st_nx = ST_RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_bank      <= 1'b0;
         r_lhbl_l    <= 1'b0;
         r_er_pend   <= 1'b0;
         r_er_addr   <= '0;
         r_rbank     <= 1'b0;
         r_valid     <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         r_lhbl_l    <= bus.LHBL;
         if (r_lhbl_l && !bus.LHBL) r_bank <= ~r_bank;
         r_cnt       <= w_run ? r_cnt : r_cnt + 1'b1;
         r_init_done <= w_run;
         r_er_pend   <= w_run && bus.rd;
         if (w_run && bus.rd) begin
            r_er_addr <= w_raddr;
            r_rbank   <= ~r_bank;
            r_valid   <= 1'b1;
         end
      end
   end

   // the pending erase targets its latched bank, so a swap cannot redirect it
   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic w_er;
      assign w_er = r_er_pend && r_rbank == 1'(b);
      jtframe_dual_ram #(.AW(AW), .DW(DW)) u_ram (
         .clk     (clk),
         .i_addr0 (w_run ? bus.wr_addr : r_cnt),
         .i_data0 (w_run ? bus.wr_data : BLANK),
         .i_we0   (!w_run || (bus.we && w_opaque && r_bank == 1'(b))),
         .i_addr1 (!w_run ? r_cnt : w_er ? r_er_addr : w_raddr),
         .i_data1 (BLANK),
         .i_we1   (!w_run || w_er),
         .i_re1   (w_run && bus.rd && r_bank != 1'(b) && !w_er),
         .o_q1    (w_q[b])
      );
   end

   assign bus.rd_data   = r_valid ? w_q[r_rbank] : BLANK;
   assign bus.init_done = r_init_done;
endmodule

// File: tb/tb_jtvigil_obj_linebuf.sv
// tb_jtvigil_obj_linebuf: directed and randomized checks of the object line
// buffer against an array model of the two banks.
module tb_jtvigil_obj_linebuf;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [7:0] mmem [2][512];
   bit   mbank;

   always #5 clk = ~clk;

   jtvigil_obj_linebuf_if #(.AW(9), .DW(8)) bus ();
   jtvigil_obj_linebuf dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 512; a++) mmem[b][a] = 8'hFF;
      mbank = 1'b0;
   endtask

   task automatic wr(input logic [8:0] x, input logic [7:0] d);
      bus.we = 1'b1; bus.wr_addr = x; bus.wr_data = d;
      cyc();
      bus.we = 1'b0;
      if (d[3:0] != 4'hF) mmem[mbank][x] = d;
   endtask

   task automatic swap();
      bus.LHBL = 1'b1;
      cyc();
      bus.LHBL = 1'b0;
      cyc();
      mbank = ~mbank;
   endtask

   task automatic rd_px(input logic [8:0] h, output logic [7:0] got, output logic [7:0] exp);
      logic [8:0] a;
      a = bus.flip ? ~h : h;
      exp = mmem[~mbank][a];
      mmem[~mbank][a] = 8'hFF;
      bus.rd = 1'b1; bus.rd_addr = h;
      cyc();
      bus.rd = 1'b0;
      got = bus.rd_data;
      cyc();
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      while (!bus.init_done && n < 600) begin
         cyc();
         n++;
      end
      total++;
      if (n !== 513) begin
         bad++;
         $display("FAIL %s init_len got=%0d want=513", tag, n);
      end
   endtask

   task automatic test_reset();
      logic [7:0] got, exp;
      #2;
      total++;
      if (bus.rd_data !== 8'hFF || bus.init_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_out rd_data=%h init_done=%b want ff/0", bus.rd_data, bus.init_done);
      end
      cyc();
      rst_n = 1'b1;
      wait_init("reset");
      model_clear();
      repeat (8) cyc();
      for (int i = 0; i < 6; i++) begin
         if (i == 3) swap();
         rd_px(9'($urandom_range(0, 511)), got, exp);
         total++;
         if (got !== 8'hFF || exp !== 8'hFF) begin
            bad++;
            $display("FAIL reset_blank got=%h want=ff", got);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] got, exp;
      wr(10, 8'h35);
      swap();
      rd_px(10, got, exp);
      total++;
      if (got !== 8'h35) begin bad++; $display("FAIL basic_read got=%h want=35", got); end
      rd_px(10, got, exp);
      total++;
      if (got !== 8'hFF) begin bad++; $display("FAIL basic_erase got=%h want=ff", got); end
   endtask

   task automatic test_alpha();
      logic [7:0] got, exp;
      wr(20, 8'h35); wr(20, 8'h7F);
      swap();
      rd_px(20, got, exp);
      total++;
      if (got !== 8'h35) begin bad++; $display("FAIL alpha_drop got=%h want=35", got); end
      wr(20, 8'h35); wr(20, 8'h72);
      swap();
      rd_px(20, got, exp);
      total++;
      if (got !== 8'h72) begin bad++; $display("FAIL last_opaque got=%h want=72", got); end
   endtask

   task automatic test_flip();
      logic [7:0] got, exp;
      bus.flip = 1'b1;
      wr(9'h1F0, 8'h41);
      swap();
      rd_px(9'h00F, got, exp);
      total++;
      if (got !== 8'h41) begin bad++; $display("FAIL flip_hit got=%h want=41", got); end
      rd_px(9'h1F0, got, exp);
      total++;
      if (got !== 8'hFF) begin bad++; $display("FAIL flip_miss got=%h want=ff", got); end
      bus.flip = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] got, exp;
      bus.LHBL = 1'b1;
      cyc();
      bus.LHBL = 1'b0;
      bus.we = 1'b1; bus.wr_addr = 30; bus.wr_data = 8'h12;
      cyc();
      bus.we = 1'b0;
      mmem[mbank][30] = 8'h12;
      mbank = ~mbank;
      rd_px(30, got, exp);
      total++;
      if (got !== 8'h12) begin bad++; $display("FAIL swap_write got=%h want=12", got); end
      swap();
      rd_px(30, got, exp);
      total++;
      if (got !== exp) begin bad++; $display("FAIL swap_write_gone got=%h want=%h", got, exp); end
   endtask

   task automatic test_random();
      logic [7:0] got, exp, d;
      logic [8:0] a;
      for (int i = 0; i < 400; i++) begin
         int unsigned op = $urandom_range(0, 9);
         if (op < 5) begin
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d[3:0] = 4'hF;
            wr(9'($urandom_range(0, 15)), d);
         end else if (op < 7) begin
            swap();
         end else begin
            bus.flip = 1'($urandom);
            a = 9'($urandom_range(0, 15));
            rd_px(bus.flip ? ~a : a, got, exp);
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL rand_read addr=%0d flip=%b got=%h want=%h", a, bus.flip, got, exp);
            end
            bus.flip = 1'b0;
         end
      end
   endtask

   task automatic test_midreset();
      logic [7:0] got, exp;
      wr(5, 8'h23); wr(6, 8'h44);
      swap();
      rd_px(5, got, exp);
      total++;
      if (got !== exp) begin bad++; $display("FAIL pre_reset got=%h want=%h", got, exp); end
      wr(7, 8'h56);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bus.rd_data !== 8'hFF || bus.init_done !== 1'b0) begin
         bad++;
         $display("FAIL midreset_out rd_data=%h init_done=%b want ff/0", bus.rd_data, bus.init_done);
      end
      bus.LHBL = 1'b1;
      repeat (3) cyc();
      rst_n = 1'b1;
      wait_init("midreset");
      model_clear();
      for (int i = 0; i < 6; i++) begin
         if (i == 3) swap();
         rd_px(9'(5 + i % 3), got, exp);
         total++;
         if (got !== 8'hFF) begin bad++; $display("FAIL midreset_blank got=%h want=ff", got); end
      end
   endtask

   initial begin
      bus.LHBL = 1'b1; bus.flip = 1'b0; bus.we = 1'b0; bus.rd = 1'b0;
      bus.wr_data = '0; bus.wr_addr = '0; bus.rd_addr = '0;
      model_clear();
      test_reset();
      test_basic();
      test_alpha();
      test_flip();
      test_back_to_back();
      test_random();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
